// File: rtl/ps2_pkg.sv
//------------------------------------------------------------------------------
// Module   : ps2_pkg
// Brief    : Shared types and constants for the PS/2 host transmitter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SEND      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_t;

    // Bits driven after the start bit: 8 data, parity, stop.
    localparam int FRAME_BITS   = 10;
    localparam int FILTER_DEPTH = 8;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_sync.sv
//------------------------------------------------------------------------------
// Module   : ps2_line_sync
// Brief    : 2-flop synchronizer for one PS/2 line, optional stability
//            filter, and a falling-edge pulse derived from the final level.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_line_sync
    import ps2_pkg::*;
#(
    parameter bit FILTER_EN = 1'b0
) (
    input  logic clk,
    input  logic reset_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic line_lvl;

    // Idle bus level is high, so flops reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
            prev_q <= line_lvl;
        end
    end

    generate
        if (FILTER_EN) begin : g_filter
            localparam int CW = $clog2(FILTER_DEPTH);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_DEPTH - 1);

            logic [CW-1:0] cnt_q;
            logic          filt_q;

            // Level flips only after FILTER_DEPTH consecutive differing samples.
            always_ff @(posedge clk) begin
                if (reset_i) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b1;
                end else if (sync_q == filt_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_q  <= '0;
                    filt_q <= sync_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign line_lvl = filt_q;
        end else begin : g_direct
            assign line_lvl = sync_q;
        end
    endgenerate

    assign level_o = line_lvl;
    assign fall_o  = prev_q & ~line_lvl;

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter, open-drain line control.
//            Define PS2_TX_GLITCH_FILTER_EN to filter the PS/2 clock input.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int FREQ_HZ    = 25_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_MS = 20
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_data_oe_o
);

    localparam int INHIBIT_CYCLES =
        int'((64'(INHIBIT_US) * 64'(FREQ_HZ)) / 64'd1_000_000);
    localparam int TIMEOUT_CYCLES =
        int'((64'(TIMEOUT_MS) * 64'(FREQ_HZ)) / 64'd1_000);

    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit CLK_FILTER_EN = 1'b1;
`else
    localparam bit CLK_FILTER_EN = 1'b0;
`endif

    ps2_state_t            state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]      inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic                  clk_oe_q, clk_oe_d;
    logic                  data_oe_q, data_oe_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic w_clk_lvl;
    logic w_clk_fall;
    logic w_data_lvl;
    logic w_data_fall_unused;
    logic w_idle;

    ps2_line_sync #(
        .FILTER_EN (CLK_FILTER_EN)
    ) u_clk_sync (
        .clk     (clk),
        .reset_i (reset_i),
        .line_i  (ps2_clk_i),
        .level_o (w_clk_lvl),
        .fall_o  (w_clk_fall)
    );

    ps2_line_sync #(
        .FILTER_EN (1'b0)
    ) u_data_sync (
        .clk     (clk),
        .reset_i (reset_i),
        .line_i  (ps2_data_i),
        .level_o (w_data_lvl),
        .fall_o  (w_data_fall_unused)
    );

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid_i) begin
                    shift_d   = {1'b1, odd_parity(tx_data_i), tx_data_i};
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inh_cnt_d = inh_cnt_q + 1'b1;
                // Data goes low one cycle before clock release so the start
                // bit is already on the bus when the device sees clock high.
                if (inh_cnt_q == INH_PRE) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (w_clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    if (!w_data_lvl) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_lvl && w_data_lvl) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout overrides everything, which also keeps done/err exclusive.
        if (state_q inside {ST_REQ, ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_q == TO_LAST) begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                done_d    = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_IDLE;
            end
        end
    end

    assign w_idle        = (state_q == ST_IDLE);
    assign tx_ready_o    = w_idle;
    assign busy_o        = ~w_idle;
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign ps2_clk_oe_o  = clk_oe_q;
    assign ps2_data_oe_o = data_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
//------------------------------------------------------------------------------
// Module   : tb_ps2_host_tx
// Brief    : Directed self-checking bench; models a PS/2 keyboard clocking at
//            12.5 kHz against a 1 MHz system clock.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ps2_host_tx;

    // 1 MHz: inhibit 100 us -> 100 cycles, timeout 20 ms -> 20000 cycles,
    // 12.5 kHz device clock -> 80-cycle period.
    localparam int FREQ_HZ = 1_000_000;
    localparam int INH_CYC = 100;
    localparam int TO_CYC  = 20_000;
    localparam int HALF    = 40;

    logic       clk;
    logic       reset_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe_o;
    logic       ps2_data_oe_o;

    logic dev_clk;
    logic dev_data;

    int n_checks;
    int n_errors;
    int done_cnt;
    int err_cnt;
    int both_cnt;
    bit glitch_en;

    ps2_host_tx #(
        .FREQ_HZ    (FREQ_HZ),
        .INHIBIT_US (100),
        .TIMEOUT_MS (20)
    ) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .ps2_clk_i     (ps2_clk_i),
        .ps2_data_i    (ps2_data_i),
        .ps2_clk_oe_o  (ps2_clk_oe_o),
        .ps2_data_oe_o (ps2_data_oe_o)
    );

    // Wired-AND open-drain bus with pull-ups.
    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe_o;
    assign ps2_data_i = dev_data & ~ps2_data_oe_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (done_o && err_o) both_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic host_req(input logic [7:0] b);
        @(negedge clk);
        chk("ready_before_req", tx_ready_o, 1);
        tx_data_i  = b;
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
        tx_data_i  = 8'h00;
    endtask

    // Request, measure the clock-inhibit phase, leave off at first REQ cycle.
    task automatic start_frame(input logic [7:0] b, input bit inject_busy);
        int inh;
        host_req(b);
        inh = 0;
        while (ps2_clk_oe_o && inh < 1000) begin
            if (inh == INH_CYC - 1) chk("data_oe_last_inhibit", ps2_data_oe_o, 1);
            if (inject_busy && inh == 10) begin
                chk("ready_while_busy", tx_ready_o, 0);
                chk("busy_while_busy", busy_o, 1);
                tx_data_i  = 8'hAA;
                tx_valid_i = 1'b1;
            end
            if (inject_busy && inh == 11) begin
                tx_valid_i = 1'b0;
                tx_data_i  = 8'h00;
            end
            @(negedge clk);
            inh++;
        end
        tx_valid_i = 1'b0;
        chk("inhibit_len", inh, INH_CYC);
        chk("start_bit", ps2_data_i, 0);
    endtask

    task automatic run_frame(input logic [7:0] b, input bit exp_par, input bit ack,
                             input bit inject_busy, input bit glitch, input int abort_at);
        int d0;
        int e0;
        logic [9:0] rx;
        d0 = done_cnt;
        e0 = err_cnt;
        rx = '0;
        start_frame(b, inject_busy);
        for (int i = 0; i < 10; i++) begin
            if (glitch && i == 3) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 13) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            rx[i]   = ps2_data_i;
            dev_clk = 1'b1;
            if (i + 1 == abort_at) begin
                @(negedge clk);
                reset_i = 1'b1;
                @(negedge clk);
                reset_i = 1'b0;
                chk("abort_clk_oe", ps2_clk_oe_o, 0);
                chk("abort_data_oe", ps2_data_oe_o, 0);
                chk("abort_ready", tx_ready_o, 1);
                chk("abort_no_pulse", {done_o, err_o}, 0);
                repeat (200) @(negedge clk);
                chk("abort_done_cnt", done_cnt - d0, 0);
                chk("abort_err_cnt", err_cnt - e0, 0);
                return;
            end
        end
        chk($sformatf("frame_%02h", b), rx, {1'b1, exp_par, b});
        if (ack) dev_data = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
        repeat (30) @(negedge clk);
        chk($sformatf("done_cnt_%02h", b), done_cnt - d0, ack ? 1 : 0);
        chk($sformatf("err_cnt_%02h", b), err_cnt - e0, ack ? 0 : 1);
        chk("ready_after_frame", tx_ready_o, 1);
    endtask

    task automatic run_timeout(input logic [7:0] b);
        int d0;
        int e0;
        int n;
        d0 = done_cnt;
        e0 = err_cnt;
        start_frame(b, 1'b0);
        n = 0;
        while (!err_o && n < TO_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, TO_CYC);
        chk("timeout_clk_oe", ps2_clk_oe_o, 0);
        chk("timeout_data_oe", ps2_data_oe_o, 0);
        chk("timeout_ready", tx_ready_o, 1);
        @(negedge clk);
        chk("timeout_err_cnt", err_cnt - e0, 1);
        chk("timeout_done_cnt", done_cnt - d0, 0);
        chk("timeout_err_one_cycle", err_o, 0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        both_cnt   = 0;
        reset_i    = 1'b1;
        tx_data_i  = 8'h00;
        tx_valid_i = 1'b0;
        dev_clk    = 1'b1;
        dev_data   = 1'b1;
`ifdef PS2_TX_GLITCH_FILTER_EN
        glitch_en = 1'b1;
`else
        glitch_en = 1'b0;
`endif
        repeat (5) @(negedge clk);
        chk("rst_ready", tx_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_clk_oe", ps2_clk_oe_o, 0);
        chk("rst_data_oe", ps2_data_oe_o, 0);
        reset_i = 1'b0;
        repeat (5) @(negedge clk);

        // Hand-computed odd parity: ED(6 ones)=1, 01=0, FF=1, 00=1, 55=1, F4(5)=0, 3C=1.
        run_frame(8'hED, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_frame(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        run_timeout(8'h12);
        repeat (20) @(negedge clk);
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        run_frame(8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_frame(8'h3C, 1'b1, 1'b1, 1'b1, glitch_en, 0);

        chk("done_err_exclusive", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared PS/2 clock/data lines.
- Sits beside the existing PS/2 keyboard receiver in the SoC top.
- Drives both lines open-drain via active-high pull-low enables.
- Asserts busy_o so the receive path can discard frames while a command is in flight.

Parameters:
- FREQ_HZ, 25_000_000, system clock frequency in Hz.
- INHIBIT_US, 100, duration the PS/2 clock is held low in the request-to-send phase, in µs.
- TIMEOUT_MS, 20, maximum time from clock release to device ack, in ms.

Ports:
- clk  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- tx_data_i  in  8  command byte
- tx_valid_i  in  1  request; byte accepted when tx_valid_i && tx_ready_o
- tx_ready_o  out  1  high only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse: device acked
- err_o  out  1  one-cycle pulse: no ack or timeout
- ps2_clk_i  in  1  PS/2 clock pin level (async)
- ps2_data_i  in  1  PS/2 data pin level (async)
- ps2_clk_oe_o  out  1  1 = pull clock low
- ps2_data_oe_o  out  1  1 = pull data low

Behaviour:
- Reset values: tx_ready_o=1; busy_o=0; done_o=0; err_o=0; both oe=0. Reset mid-frame releases both lines on the next edge and returns to IDLE with no done/err pulse.
- Inputs pass through a 2-flop synchronizer. A falling edge is synced clock 1→0, detected in the cycle after the sync output changes.
- Accept: latch tx_data_i, compute odd parity p = ~^tx_data_i, load shift register {1'b1(stop), p, data[7:0]}.

State machine:
- IDLE → INHIBIT on accept.
- INHIBIT: clk_oe=1, data_oe=0. Count INHIBIT_US*FREQ_HZ/1e6 cycles (2500 at defaults). In the last INHIBIT cycle assert data_oe=1, then go to REQ.
- REQ: clk_oe=0, data_oe=1 (start bit). Start the timeout counter; bit counter = 0.
- SEND: on each falling edge, drive the next shift bit LSB first (data_oe = ~bit) and increment the bit counter.
  - Edges 1-8: data bits. Edge 9: parity. Edge 10: stop (data released).
  - After edge 10 go to ACK.
- ACK: on the next falling edge, sample synced data.
  - 0 → WAIT_IDLE.
  - 1 → err_o pulse, go to IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1, then done_o pulse and go to IDLE.
- Timeout: if the counter reaches TIMEOUT_MS*FREQ_HZ/1000 in REQ, SEND, ACK or WAIT_IDLE:
  - release both lines;
  - err_o pulse;
  - go to IDLE.
- tx_valid_i while busy is ignored; no queueing.
- done_o and err_o are never asserted in the same cycle.
- Counter widths come from $clog2 of the cycle counts.

Optional Feature:
- PS2_TX_GLITCH_FILTER_EN
  - Defined: the synced clock passes a stability filter. The filtered level changes only after 8 consecutive identical samples, and edges come from the filtered level. This adds 8 cycles of edge latency.
  - Undefined: edges come straight from the 2-flop output.
  - Protocol timing is otherwise identical.

Decomposition:
- ps2_pkg: state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE), frame length constant (10 driven bits), filter depth constant (8).
- One sub-module, ps2_line_sync: synchronizer, optional glitch filter, falling-edge pulse output. Instantiated for clock and data; only the clock instance uses the edge output.

Test Plan:
- Send 0xED; bench device clocks at 12.5 kHz and acks → clock held low 2500 cycles. Start bit 0, then bits 1,0,1,1,0,1,1,1, parity 1, stop 1. done_o pulses once.
- Send 0x01, then 0xFF → parity bits 0 and 1 respectively. Both frames complete with done_o.
- Device never clocks after REQ → err_o pulse at 500,000 cycles after REQ entry, both oe=0, tx_ready_o=1.
- Device leaves data high on the 11th clock → err_o pulse, no done_o.
- Reset_i asserted after edge 5 of a 0x55 send → next cycle: both oe=0, tx_ready_o=1, no pulses. A new 0xF4 send then completes normally.
- tx_valid_i pulsed with 0xAA during busy → ignored; the in-flight byte is transmitted unchanged. With PS2_TX_GLITCH_FILTER_EN defined, a 3-cycle low glitch on the clock produces no bit advance.
